// File: rtl/trdb_packet_serializer.sv
`default_nettype none
// ============================================================================
//  Module   : trdb_packet_serializer
//  Purpose  : Buffers variable-length trace packets in a small FIFO and
//             emits each packet as a sequence of WORD_W-bit words over a
//             valid/ready stream. Bits past the packet length in the final
//             word are zeroed, and the final word is flagged.
//
//  Ports    : clk_i          - clock
//             rst_i          - asynchronous reset, active-high
//             flush_i        - synchronous flush of all buffered state
//             packet_bits_i  - packet payload, LSB is sent first
//             packet_len_i   - valid payload length in bits
//             packet_valid_i - packet offered
//             packet_ready_o - packet accepted when high together with valid
//             word_o         - output word
//             word_valid_o   - word_o is valid
//             word_ready_i   - sink accepts the word
//             word_last_o    - word_o is the final word of its packet
//             overflow_o     - sticky: a packet was offered while full
//
//  Options  : TRDB_SER_HEADER_EN - when defined, each packet is preceded by
//             a header word {8'hA5, seq[7:0], 0, len_clamped}.
//
//  Revision : 1.0 - initial release
// ============================================================================
module trdb_packet_serializer #(
  parameter int PACKET_W   = 128,
  parameter int WORD_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int LEN_W      = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_i,
  input  logic [PACKET_W-1:0] packet_bits_i,
  input  logic [LEN_W-1:0]    packet_len_i,
  input  logic                packet_valid_i,
  output logic                packet_ready_o,
  output logic [WORD_W-1:0]   word_o,
  output logic                word_valid_o,
  input  logic                word_ready_i,
  output logic                word_last_o,
  output logic                overflow_o
);

  // --------------------------------------------------------------------------
  // Derived constants
  // --------------------------------------------------------------------------
  localparam int NSLICE = PACKET_W / WORD_W;
  localparam int ADDR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PTR_W  = ADDR_W + 1;
  localparam int WSH    = $clog2(WORD_W);
  // Word index must reach NSLICE when a header word precedes the data.
  localparam int IDX_W  = $clog2(NSLICE + 1);

  localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(PACKET_W);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                overflow_q, overflow_d;

  logic [PACKET_W-1:0] mem_bits_q [FIFO_DEPTH];
  logic [LEN_W-1:0]    mem_len_q  [FIFO_DEPTH];

  // --------------------------------------------------------------------------
  // FIFO status
  // --------------------------------------------------------------------------
  logic empty;
  logic full;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  // Ready is a pure function of registered pointers, so the sink side can
  // never create a combinational path back to the packet source.
  assign packet_ready_o = !full;

  // --------------------------------------------------------------------------
  // Input side: clamp length, decide whether the packet is stored
  // --------------------------------------------------------------------------
  logic [LEN_W-1:0] len_clamped;
  logic             push;

  assign len_clamped = (packet_len_i > LEN_MAX) ? LEN_MAX : packet_len_i;

  // Zero-length packets complete the handshake but never occupy an entry.
  assign push = packet_valid_i && !full && (packet_len_i != '0) && !flush_i;

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_bits_q[wr_ptr_q[ADDR_W-1:0]] <= packet_bits_i;
      mem_len_q[wr_ptr_q[ADDR_W-1:0]]  <= len_clamped;
    end
  end

  // --------------------------------------------------------------------------
  // Head-of-FIFO decode
  // --------------------------------------------------------------------------
  logic [PACKET_W-1:0] head_bits;
  logic [LEN_W-1:0]    head_len;
  logic [LEN_W-1:0]    len_m1;
  logic [IDX_W-1:0]    last_slice;
  logic [WSH-1:0]      rem;

  assign head_bits = mem_bits_q[rd_ptr_q[ADDR_W-1:0]];
  assign head_len  = mem_len_q[rd_ptr_q[ADDR_W-1:0]];

  // Stored lengths are always >= 1, so (len-1)/WORD_W is nwords-1 exactly.
  assign len_m1     = head_len - LEN_W'(1);
  assign last_slice = IDX_W'(len_m1 >> WSH);
  assign rem        = head_len[WSH-1:0];

  logic             is_header;
  logic [IDX_W-1:0] last_idx;
  logic [IDX_W-1:0] slice_sel;

`ifdef TRDB_SER_HEADER_EN
  logic [7:0]        seq_q, seq_d;
  logic [WORD_W-1:0] hdr_word;

  // Word index 0 is the header; data slices are shifted up by one.
  assign is_header = (idx_q == '0);
  assign last_idx  = last_slice + IDX_W'(1);
  assign slice_sel = idx_q - IDX_W'(1);

  always_comb begin
    hdr_word              = '0;
    hdr_word[31:24]       = 8'hA5;
    hdr_word[23:16]       = seq_q;
    hdr_word[LEN_W-1:0]   = head_len;
  end
`else
  assign is_header = 1'b0;
  assign last_idx  = last_slice;
  assign slice_sel = idx_q;
`endif

  // --------------------------------------------------------------------------
  // Slice selection and tail masking
  // --------------------------------------------------------------------------
  logic [WORD_W-1:0] slice_word;
  logic [WORD_W-1:0] data_word;
  logic              on_last;

  always_comb begin
    slice_word = '0;
    for (int s = 0; s < NSLICE; s++) begin
      if (slice_sel == IDX_W'(s)) begin
        slice_word = head_bits[s*WORD_W +: WORD_W];
      end
    end
  end

  assign on_last = (idx_q == last_idx);

  // A remainder of zero means the final slice is completely filled.
  always_comb begin
    data_word = slice_word;
    if (on_last && (rem != '0)) begin
      data_word = slice_word & ~({WORD_W{1'b1}} << rem);
    end
  end

  // --------------------------------------------------------------------------
  // Output stream
  // --------------------------------------------------------------------------
  always_comb begin
    word_valid_o = !empty;
    word_last_o  = !empty && on_last;
    word_o       = '0;
    if (!empty) begin
`ifdef TRDB_SER_HEADER_EN
      word_o = is_header ? hdr_word : data_word;
`else
      word_o = data_word;
`endif
    end
  end

  assign overflow_o = overflow_q;

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  logic accept;
  logic pop;

  assign accept = word_valid_o && word_ready_i;
  assign pop    = accept && word_last_o;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    idx_d      = idx_q;
    overflow_d = overflow_q;
    if (flush_i) begin
      // Flush outranks any push, pop or overflow in the same cycle.
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      idx_d      = '0;
      overflow_d = 1'b0;
    end else begin
      if (push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
        idx_d    = '0;
      end else if (accept) begin
        idx_d = idx_q + IDX_W'(1);
      end
      // Full is judged on registered state: a same-cycle pop does not help.
      if (packet_valid_i && full) begin
        overflow_d = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      idx_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      idx_q      <= idx_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef TRDB_SER_HEADER_EN
  // Sequence number advances only when the sink takes a header word.
  always_comb begin
    seq_d = seq_q;
    if (flush_i) begin
      seq_d = '0;
    end else if (accept && is_header) begin
      seq_d = seq_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      seq_q <= '0;
    end else begin
      seq_q <= seq_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: doc/trdb_packet_serializer.md
Name: trdb_packet_serializer

Overview:
- Sits directly downstream of the trace packet generator; consumes its variable-length 128-bit packets.
- Buffers packets in a small FIFO and emits each one as a sequence of 32-bit words over a valid/ready stream to the trace sink (APB readout FIFO / off-chip port).
- Masks unused bits of the final word and flags the last word of each packet.

Parameters:
- PACKET_W, 128, packet width in bits; must be a multiple of WORD_W.
- WORD_W, 32, output word width.
- FIFO_DEPTH, 4, packet buffer depth; power of two, minimum 2.
- LEN_W, 8, width of the packet length field; packet length is in bits.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- flush_i  in  1  synchronous flush of all buffered state.
- packet_bits_i  in  PACKET_W  packet payload; LSB is sent first.
- packet_len_i  in  LEN_W  valid payload length in bits.
- packet_valid_i  in  1  packet offered.
- packet_ready_o  out  1  packet accepted when high with valid.
- word_o  out  WORD_W  output word.
- word_valid_o  out  1  word_o is valid.
- word_ready_i  in  1  sink accepts the word.
- word_last_o  out  1  word_o is the final word of its packet.
- overflow_o  out  1  sticky: a packet was offered while the FIFO was full.

Behaviour:
- Clock and reset: one clock, clk_i. rst_i is asynchronous and active-high.
- Reset values: FIFO empty, slice counter 0, word_valid_o=0, word_last_o=0, word_o=0, overflow_o=0, packet_ready_o=1 (once reset is deasserted).
- Packet input handshake:
  - packet_ready_o = !full. Ready depends only on registered state, with no combinational path from word_ready_i.
  - A full FIFO refuses a packet even if a pop happens in the same cycle.
- Push: on valid && ready, store {bits, len}.
  - A len above PACKET_W is clamped to PACKET_W.
  - len==0 packets are accepted and silently dropped: no FIFO write and no output words.
- Word count: nwords = (len_clamped + WORD_W-1) / WORD_W, range 1..PACKET_W/WORD_W.
- Output, combinational from the FIFO head:
  - word_valid_o = !empty.
  - word_o = head slice[idx]. On the final slice, bits at positions >= (len mod WORD_W) are forced to 0 when len mod WORD_W != 0.
  - word_last_o = word_valid_o && (idx == nwords-1).
  - word_o reads 0 when empty.
- Word advance: on word_valid_o && word_ready_i, idx increments. On the last word, idx returns to 0 and the head is popped.
- Latency: a packet accepted at edge N presents its first word in the cycle after edge N. A single-word packet frees its FIFO entry at the edge where that word is accepted.
- Backpressure: word_o, word_last_o and idx are held stable while word_valid_o && !word_ready_i.
- Simultaneous push and pop in the same cycle (FIFO not full): both take effect and occupancy is unchanged.
- Pointer wrap: pointers are log2(FIFO_DEPTH)+1 bits. Full when the MSBs differ and the rest are equal; wrap-around is seamless.
- Overflow: packet_valid_i && !packet_ready_o sets overflow_o. It clears only on rst_i or flush_i, and the dropped packet is lost.
- Flush: flush_i has priority over push and pop in the same cycle.
  - Clears the FIFO, idx and overflow_o; any partially sent packet is abandoned.
  - word_valid_o=0 in the following cycle.
  - packet_ready_o stays 1 during flush, but a packet offered in the flush cycle is discarded.
- Reset mid-packet: all state returns to reset values immediately and asynchronously.

Optional Feature:
- Macro: TRDB_SER_HEADER_EN.
- When defined, each packet is preceded by one header word:
  - [31:24]=8'hA5, [23:16]=seq, [15:LEN_W]=0, [LEN_W-1:0]=len_clamped.
  - seq is an 8-bit counter that increments when a header word is accepted and wraps 255->0. It is reset to 0 by rst_i and flush_i.
  - The header is never the last word, since every packet has at least 1 data word.
- When not defined: no header, no seq register; output is data words only.

Test Plan (all with the macro undefined unless stated):
1. Reset, then push bits=128'h...DDDD_CCCC_BBBB_AAAA (slices 0..3 = AAAA,BBBB,CCCC,DDDD), len=128, word_ready_i=1 -> 4 consecutive words AAAA,BBBB,CCCC,DDDD starting 1 cycle after accept; word_last_o only on DDDD.
2. Push len=40, bits slice0=32'h12345678, slice1=32'hFFFFFFFF -> words 32'h12345678 then 32'h000000FF, last on the second; len=0 -> no words, overflow_o stays 0.
3. word_ready_i=0, push 5 packets of len=32 -> packet_ready_o drops after 4, overflow_o=1; set ready=1 -> exactly 4 words drain in order, overflow_o remains 1.
4. Toggle word_ready_i every cycle during a 3-word packet -> each word is held stable until accepted; no word is duplicated or skipped.
5. Assert flush_i during word 2 of a 4-word packet with 2 packets queued -> next cycle word_valid_o=0, overflow_o=0, and a new packet pushed afterwards is sent from its slice 0.
6. With TRDB_SER_HEADER_EN defined, push 2 packets of len=64 -> words A500_0040, d0, d1(last), A501_0040, d0, d1(last); after 256 packets seq wraps to 00.
